// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives instruction_memory and
// presents each fetched word to decode over a registered valid/ready port.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] LAST_ADDR = 32'd52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        past_end;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign past_end = pc_q > LAST_ADDR;
  assign redir_pc = redirect_addr & 32'hFFFF_FFFC;
  assign pc_inc   = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else if (past_end) begin
          state_d = S_HALT;
        end else begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          pc_d    = pc_inc;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // redirect wins: the presented word is dropped uncounted
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (if_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (past_end) begin
            state_d = S_HALT;
          end else begin
            instr_d = imem_instr;
            ipc_d   = pc_q;
            pc_d    = pc_inc;
          end
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_valid    = (state_q == S_VALID);
  assign halted      = (state_q == S_HALT);
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller against a
// transaction-level model of the fetch stream.
module tb_fetch_controller;

  localparam logic [31:0] LAST = 32'd52;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        halted;
  logic [15:0] fetch_count;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:13];

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [31:0] a);
    if (a <= LAST && a[1:0] == 2'b00) return mem[a[5:2]];
    return {16'hBAD0, a[15:0]};
  endfunction

  always_comb imem_instr = memf(imem_addr);

  // Model: a started/halted flag, a fetch pointer, an optional
  // presented word, and a pending-fetch flag after start/redirect.
  bit          m_started, m_halted, m_pend, m_has;
  logic [31:0] m_ptr, m_ppc, m_pins;
  int          m_cnt;

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_pend = 0; m_has = 0;
    m_ptr = 32'd0; m_ppc = 32'd0; m_pins = 32'd0; m_cnt = 0;
  endtask

  task automatic present_next();
    m_ppc  = m_ptr;
    m_pins = memf(m_ptr);
    m_ptr  = m_ptr + 32'd4;
    m_has  = 1;
  endtask

  task automatic model_step(bit st, bit rdy, bit rv, logic [31:0] ra);
    if (!m_started) begin
      if (st) begin m_started = 1; m_pend = 1; end
    end else if (rv) begin
      m_ptr = {ra[31:2], 2'b00};
      m_has = 0; m_halted = 0; m_pend = 1;
    end else if (m_halted) begin
    end else if (m_pend) begin
      m_pend = 0;
      if (m_ptr > LAST) m_halted = 1;
      else present_next();
    end else if (m_has && rdy) begin
      m_cnt = m_cnt + 1;
      if (m_ptr > LAST) begin m_has = 0; m_halted = 1; end
      else present_next();
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".addr"}, imem_addr, m_ptr);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_has});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".count"}, {16'd0, fetch_count}, m_cnt & 32'hFFFF);
    chk({tag, ".pc"}, if_pc, m_ppc);
    chk({tag, ".instr"}, if_instr, m_pins);
  endtask

  task automatic step(string tag, bit st, bit rdy, bit rv, logic [31:0] ra);
    start = st; if_ready = rdy; redirect_valid = rv; redirect_addr = ra;
    model_step(st, rdy, rv, ra);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 14; i++) mem[i] = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b0;
    step("idle", 0, 1, 1, 32'd8);
    chk("idle.addr0", imem_addr, 32'd0);

    // full run
    step("t1.start", 1, 1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step("t1.run", 0, 1, 0, 0);
      chk("t1.pc", if_pc, 32'(4 * i));
      chk("t1.v", {31'd0, if_valid}, 32'd1);
    end
    step("t1.end", 0, 1, 0, 0);
    chk("t1.halt", {31'd0, halted}, 32'd1);
    chk("t1.cnt", {16'd0, fetch_count}, 32'd14);
    chk("t1.addr", imem_addr, 32'd56);

    // restart from halt
    step("t6.redir", 0, 0, 1, 32'd0);
    chk("t6.h0", {31'd0, halted}, 32'd0);
    step("t6.fetch", 0, 0, 0, 0);
    chk("t6.pc", if_pc, 32'd0);
    chk("t6.cnt", {16'd0, fetch_count}, 32'd14);

    // backpressure
    step("t2.a", 0, 1, 0, 0);
    step("t2.b", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t2.hold", 0, 0, 0, 0);
      chk("t2.pc", if_pc, 32'd8);
      chk("t2.addr", imem_addr, 32'd12);
      chk("t2.cnt", {16'd0, fetch_count}, 32'd16);
    end
    step("t2.go", 0, 1, 0, 0);
    chk("t2.pc12", if_pc, 32'd12);

    // redirect with simultaneous handshake
    step("t3.redir", 0, 1, 1, 32'd40);
    chk("t3.v0", {31'd0, if_valid}, 32'd0);
    chk("t3.cnt", {16'd0, fetch_count}, 32'd17);
    for (int i = 0; i < 4; i++) begin
      step("t3.run", 0, 1, 0, 0);
      chk("t3.pc", if_pc, 32'(40 + 4 * i));
    end
    step("t3.end", 0, 1, 0, 0);
    chk("t3.halt", {31'd0, halted}, 32'd1);
    chk("t3.cnt2", {16'd0, fetch_count}, 32'd21);

    // misaligned and out-of-range redirect
    step("t4.mis", 0, 0, 1, 32'h2B);
    step("t4.f", 0, 0, 0, 0);
    chk("t4.pc", if_pc, 32'h28);
    step("t4.far", 0, 1, 1, 32'd100);
    step("t4.h", 0, 1, 0, 0);
    chk("t4.halt", {31'd0, halted}, 32'd1);
    chk("t4.v", {31'd0, if_valid}, 32'd0);
    chk("t4.cnt", {16'd0, fetch_count}, 32'd21);

    // reset between edges
    step("t5.redir", 0, 0, 1, 32'd16);
    step("t5.f", 0, 1, 0, 0);
    step("t5.n", 0, 1, 0, 0);
    chk("t5.pc20", if_pc, 32'd20);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t5.async");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t5.idle", 0, 1, 1, 32'd24);

    // randomized traffic
    step("rnd.start", 1, 1, 0, 0);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra;
      bit rdy, rv, st;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 15) == 0);
      ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70));
      step("rnd", st, rdy, rv, ra);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
